uart_rx: RTL and testbench

Serial-to-parallel UART receiver, the receive-side counterpart of the UART TX frame path (start, data, optional parity, stop). Oversamples RX_IN by a configurable prescale, majority-votes each bit, checks start glitch, parity and stop, and delivers one byte per frame with a single-cycle valid strobe to the system controller in the UART clock domain.

---
 rtl/uart_pkg.sv | 38 +++
 rtl/uart_rx_if.sv | 42 ++++
 rtl/uart_rx_sampler.sv | 58 +++++
 rtl/uart_rx.sv | 158 +++++++++++++++
 tb/tb_uart_rx.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path:
//   uart_state_e        receiver FSM states (IDLE, START, DATA, PARITY, STOP)
//   PAR_EVEN / PAR_ODD  encodings of the PAR_TYP input
//   PRESCALE_8/16/32    legal oversampling ratios
//   legal_prescale()    maps any Prescale value onto a legal ratio (default 8)
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  // Unsupported ratios fall back to 8 so the edge counter always has a
  // sane terminal count.
  function automatic logic [5:0] legal_prescale(input logic [5:0] p);
    logic [5:0] r;
    case (p)
      PRESCALE_16: r = PRESCALE_16;
      PRESCALE_32: r = PRESCALE_32;
      default:     r = PRESCALE_8;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if
// Signal bundle between the serial line / configuration source and the
// UART receiver.
//   RX_IN       serial line, idles high
//   Prescale    oversampling ratio request (8, 16, 32; others act as 8)
//   PAR_EN      parity bit present in frame
//   PAR_TYP     0 = even, 1 = odd
//   P_DATA      last good received byte
//   data_valid  one-cycle strobe: P_DATA is new
//   par_err     one-cycle strobe: parity mismatch
//   stp_err     one-cycle strobe: stop bit sampled 0
//   dbg_state   receiver FSM state, for observation only
// Handshake: data_valid/par_err/stp_err are pure one-cycle strobes with no
// ready; the consumer cannot stall the receiver and must take P_DATA in the
// strobe cycle or later (it is held until the next good frame).
// Modports: slave = receiver side, master = line/controller side.
// ---------------------------------------------------------------------------
interface uart_rx_if #(parameter int DATA_WIDTH = 8);
  import uart_pkg::*;

  logic                  RX_IN;
  logic [5:0]            Prescale;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;
  uart_state_e           dbg_state;

  modport slave (
    input  RX_IN, Prescale, PAR_EN, PAR_TYP,
    output P_DATA, data_valid, par_err, stp_err, dbg_state
  );

  modport master (
    output RX_IN, Prescale, PAR_EN, PAR_TYP,
    input  P_DATA, data_valid, par_err, stp_err, dbg_state
  );

endinterface

// File: rtl/uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_sampler
// Per-bit edge counter and 3-capture majority vote.
//   i_clk       UART oversampling clock
//   i_rst_n     synchronous active-low reset
//   i_rx        serial line
//   i_idle      receiver is in IDLE (counter parked, start detection)
//   i_prescale  latched legal oversampling ratio P
//   o_bit       majority of captures at edges P/2-1, P/2, P/2+1
//   o_bit_end   high in the last oversampling cycle of a bit (edge P-1)
// o_bit is stable from edge P/2+2 until the next bit's first capture.
// ---------------------------------------------------------------------------
module uart_rx_sampler (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  input  logic       i_idle,
  input  logic [5:0] i_prescale,
  output logic       o_bit,
  output logic       o_bit_end
);

  logic [5:0] r_edge_cnt;
  logic [2:0] r_cap;
  logic [5:0] w_half;
  logic [5:0] w_last;

  assign w_half = i_prescale >> 1;
  assign w_last = i_prescale - 6'd1;

  // In IDLE the cycle that sees the line low is edge 0 of the start bit,
  // so the counter continues from 1.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_edge_cnt <= 6'd0;
    end else if (i_idle) begin
      r_edge_cnt <= i_rx ? 6'd0 : 6'd1;
    end else if (r_edge_cnt == w_last) begin
      r_edge_cnt <= 6'd0;
    end else begin
      r_edge_cnt <= r_edge_cnt + 6'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cap <= 3'b000;
    end else begin
      if (r_edge_cnt == w_half - 6'd1) r_cap[0] <= i_rx;
      if (r_edge_cnt == w_half)        r_cap[1] <= i_rx;
      if (r_edge_cnt == w_half + 6'd1) r_cap[2] <= i_rx;
    end
  end

  assign o_bit     = (r_cap[0] & r_cap[1]) | (r_cap[0] & r_cap[2]) | (r_cap[1] & r_cap[2]);
  assign o_bit_end = !i_idle && (r_edge_cnt == w_last);

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// Oversampling UART receiver: start, DATA_WIDTH data bits LSB first,
// optional parity, one stop bit. Delivers one byte per good frame with a
// one-cycle data_valid strobe; bad frames raise par_err and/or stp_err.
//   CLK   UART oversampling clock
//   RST   synchronous active-low reset
//   bus   uart_rx_if.slave (RX_IN, Prescale, PAR_EN, PAR_TYP in;
//         P_DATA, data_valid, par_err, stp_err, dbg_state out)
// Build option: define UART_RX_PARITY_EN to include the PARITY state and
// the parity checker. Without it PAR_EN/PAR_TYP are ignored, every frame is
// DATA_WIDTH+2 bits and par_err is tied low.
// ---------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic     CLK,
  input  logic     RST,
  uart_rx_if.slave bus
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  uart_state_e           r_state;
  uart_state_e           w_next;
  logic [CW-1:0]         r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_pdata;
  logic [5:0]            r_prescale;
  logic                  r_dv;
  logic                  r_se;
  logic                  w_bit;
  logic                  w_bit_end;
  logic                  w_idle;
  logic                  w_start;
  logic                  w_frame_end;
  logic                  w_use_parity;
  logic                  w_par_bad;

  assign w_idle = (r_state == IDLE);

  uart_rx_sampler u_sampler (
    .i_clk      (CLK),
    .i_rst_n    (RST),
    .i_rx       (bus.RX_IN),
    .i_idle     (w_idle),
    .i_prescale (r_prescale),
    .o_bit      (w_bit),
    .o_bit_end  (w_bit_end)
  );

  // FSM state register
  always_ff @(posedge CLK) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // FSM next state; w_frame_end marks the last cycle of the stop bit
  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      IDLE: begin
        if (!bus.RX_IN) begin
          w_next  = START;
          w_start = 1'b1;
        end
      end
      START: begin
        // A start bit that votes high was a glitch: drop it silently.
        if (w_bit_end) w_next = w_bit ? IDLE : DATA;
      end
      DATA: begin
        if (w_bit_end && (r_bit_cnt == LAST_BIT)) w_next = w_use_parity ? PARITY : STOP;
      end
      PARITY: begin
        if (w_bit_end) w_next = STOP;
      end
      STOP: begin
        if (w_bit_end) begin
          w_next      = IDLE;
          w_frame_end = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath: configuration latch, shift register, frame-end outputs
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_prescale <= PRESCALE_8;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_pdata    <= '0;
      r_dv       <= 1'b0;
      r_se       <= 1'b0;
    end else begin
      if (w_start) r_prescale <= legal_prescale(bus.Prescale);
      if ((r_state == DATA) && w_bit_end) begin
        r_shift   <= {w_bit, r_shift[DATA_WIDTH-1:1]};
        r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + 1'b1;
      end
      // In STOP, w_bit at frame end is the voted stop bit.
      r_dv <= w_frame_end && w_bit && !w_par_bad;
      r_se <= w_frame_end && !w_bit;
      if (w_frame_end && w_bit && !w_par_bad) r_pdata <= r_shift;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_en;
  logic r_par_typ;
  logic r_par_bad;
  logic r_pe;

  assign w_use_parity = r_par_en;
  assign w_par_bad    = r_par_bad;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_par_en  <= 1'b0;
      r_par_typ <= PAR_EVEN;
      r_par_bad <= 1'b0;
      r_pe      <= 1'b0;
    end else begin
      if (w_start) begin
        r_par_en  <= bus.PAR_EN;
        r_par_typ <= bus.PAR_TYP;
        r_par_bad <= 1'b0;
      end else if ((r_state == PARITY) && w_bit_end) begin
        // Expected bit is XOR of data XOR PAR_TYP; any difference is an error.
        r_par_bad <= w_bit ^ (^r_shift) ^ r_par_typ;
      end
      r_pe <= w_frame_end && r_par_bad;
    end
  end

  assign bus.par_err = r_pe;
`else
  logic w_unused_par;

  assign w_use_parity = 1'b0;
  assign w_par_bad    = 1'b0;
  assign w_unused_par = ^{bus.PAR_EN, bus.PAR_TYP};
  assign bus.par_err  = 1'b0;
`endif

  assign bus.P_DATA     = r_pdata;
  assign bus.data_valid = r_dv;
  assign bus.stp_err    = r_se;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx. Frames are driven bit by bit on the falling
// edge; for each frame the driver predicts, from the frame contents alone,
// the cycle and kind of the end-of-frame strobe and queues it. One compare
// process checks every strobe and P_DATA on every cycle against that queue.
// Literal latency/byte checks pin the model to hand-computed numbers.
// ---------------------------------------------------------------------------
module tb_uart_rx;
  import uart_pkg::*;

`ifdef UART_RX_PARITY_EN
  localparam bit PARITY_BUILT = 1'b1;
`else
  localparam bit PARITY_BUILT = 1'b0;
`endif

  typedef struct {
    int         cyc;
    bit         dv;
    bit         pe;
    bit         se;
    logic [7:0] data;
  } ev_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  ev_t        exp_q[$];
  logic [7:0] exp_pdata = 8'h00;

  int last_dv = -1, prev_dv = -1, n_dv = 0;
  int last_pe = -1, n_pe = 0;
  int last_se = -1, n_se = 0;

  uart_rx_if #(.DATA_WIDTH(8)) bus();

  uart_rx #(.DATA_WIDTH(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // ---------------- clock / watchdog ----------------
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: cycle %0d got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  // Sampled 2 time units after each rising edge: cycle index = cyc.
  bit e_dv, e_pe, e_se;
  always @(posedge CLK) begin
    cyc++;
    #2;
    e_dv = 1'b0;
    e_pe = 1'b0;
    e_se = 1'b0;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      chk("strobe_missing", 32'(cyc), 32'(exp_q[0].cyc));
      void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e_dv = exp_q[0].dv;
      e_pe = exp_q[0].pe;
      e_se = exp_q[0].se;
      if (exp_q[0].dv) exp_pdata = exp_q[0].data;
      void'(exp_q.pop_front());
    end
    chk("data_valid", 32'(bus.data_valid), 32'(e_dv));
    chk("par_err",    32'(bus.par_err),    32'(e_pe));
    chk("stp_err",    32'(bus.stp_err),    32'(e_se));
    chk("p_data",     32'(bus.P_DATA),     32'(exp_pdata));
    if (bus.data_valid === 1'b1) begin prev_dv = last_dv; last_dv = cyc; n_dv++; end
    if (bus.par_err === 1'b1)    begin last_pe = cyc; n_pe++; end
    if (bus.stp_err === 1'b1)    begin last_se = cyc; n_se++; end
  end

  // ---------------- driver ----------------
  // Called on a falling edge while the receiver is idle; that cycle is t0.
  // abort_at >= 0 pulls RST low in cycle t0+abort_at and abandons the frame.
  task automatic send_frame(input int p, input bit pen, input bit ptyp,
                            input logic [7:0] d, input bit flip_par,
                            input bit stop_bit, input int abort_at,
                            output int t0);
    logic [11:0] bits;
    int          nb;
    int          eff_p;
    bit          has_par;
    ev_t         ev;
    eff_p   = (p == 16 || p == 32) ? p : 8;
    has_par = PARITY_BUILT && pen;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    nb = 9;
    if (has_par) begin
      // Even parity: total ones over data+parity is even; odd flips it.
      bits[nb] = (^d) ^ ptyp ^ flip_par;
      nb++;
    end
    bits[nb] = stop_bit;
    nb++;
    bus.Prescale = 6'(p);
    bus.PAR_EN   = pen;
    bus.PAR_TYP  = ptyp;
    t0     = cyc;
    ev.cyc = t0 + nb * eff_p;
    ev.pe  = has_par && flip_par;
    ev.se  = !stop_bit;
    ev.dv  = !ev.pe && !ev.se;
    ev.data = d;
    exp_q.push_back(ev);
    for (int k = 0; k < nb * eff_p; k++) begin
      if (k == abort_at) begin
        RST        = 1'b0;
        bus.RX_IN  = 1'b1;
        exp_q.delete();
        exp_pdata  = 8'h00;
        @(negedge CLK);
        chk("midrst_pdata", 32'(bus.P_DATA), 32'h0);
        chk("midrst_valid", 32'(bus.data_valid), 32'h0);
        chk("midrst_state", 32'(bus.dbg_state), 32'(IDLE));
        RST = 1'b1;
        return;
      end
      bus.RX_IN = bits[k / eff_p];
      @(negedge CLK);
    end
    bus.RX_IN = 1'b1;
  endtask

  // ---------------- directed tests ----------------
  int t0, t0b, dv_before, se_before;

  initial begin
    bus.RX_IN    = 1'b1;
    bus.Prescale = PRESCALE_8;
    bus.PAR_EN   = 1'b0;
    bus.PAR_TYP  = PAR_EVEN;
    repeat (3) @(negedge CLK);
    chk("rst_pdata", 32'(bus.P_DATA), 32'h0);
    chk("rst_valid", 32'(bus.data_valid), 32'h0);
    chk("rst_state", 32'(bus.dbg_state), 32'(IDLE));
    RST = 1'b1;
    repeat (4) @(negedge CLK);

    // P=8, no parity, 0xA5
    send_frame(8, 1'b0, PAR_EVEN, 8'hA5, 1'b0, 1'b1, -1, t0);
    repeat (3) @(negedge CLK);
    chk("a5_latency", 32'(last_dv - t0), 32'd80);
    chk("a5_pdata", 32'(bus.P_DATA), 32'hA5);

`ifdef UART_RX_PARITY_EN
    // P=16, even parity, 0x3C good then bad parity bit
    send_frame(16, 1'b1, PAR_EVEN, 8'h3C, 1'b0, 1'b1, -1, t0);
    repeat (3) @(negedge CLK);
    chk("par_ok_latency", 32'(last_dv - t0), 32'd176);
    chk("par_ok_pdata", 32'(bus.P_DATA), 32'h3C);
    dv_before = n_dv;
    send_frame(16, 1'b1, PAR_EVEN, 8'h3C, 1'b1, 1'b1, -1, t0);
    repeat (3) @(negedge CLK);
    chk("par_bad_latency", 32'(last_pe - t0), 32'd176);
    chk("par_bad_no_dv", 32'(n_dv), 32'(dv_before));
    chk("par_bad_pdata", 32'(bus.P_DATA), 32'h3C);
`else
    // Parity disabled in this build: PAR_EN is ignored, frame stays 10 bits
    send_frame(16, 1'b1, PAR_EVEN, 8'h3C, 1'b0, 1'b1, -1, t0);
    repeat (3) @(negedge CLK);
    chk("nopar_latency", 32'(last_dv - t0), 32'd160);
    chk("nopar_pdata", 32'(bus.P_DATA), 32'h3C);
`endif

    // P=8, 0x5A with stop bit 0
    dv_before = n_dv;
    send_frame(8, 1'b0, PAR_EVEN, 8'h5A, 1'b0, 1'b0, -1, t0);
    repeat (3) @(negedge CLK);
    chk("stp_latency", 32'(last_se - t0), 32'd80);
    chk("stp_no_dv", 32'(n_dv), 32'(dv_before));
    chk("stp_pdata", 32'(bus.P_DATA), 32'h3C);

    // Two-cycle glitch, then a normal 0x01 frame
    dv_before = n_dv;
    se_before = n_se;
    bus.Prescale = PRESCALE_8;
    bus.RX_IN = 1'b0;
    repeat (2) @(negedge CLK);
    bus.RX_IN = 1'b1;
    repeat (16) @(negedge CLK);
    chk("glitch_state", 32'(bus.dbg_state), 32'(IDLE));
    chk("glitch_no_dv", 32'(n_dv), 32'(dv_before));
    chk("glitch_no_se", 32'(n_se), 32'(se_before));
    send_frame(8, 1'b0, PAR_EVEN, 8'h01, 1'b0, 1'b1, -1, t0);
    repeat (3) @(negedge CLK);
    chk("after_glitch_latency", 32'(last_dv - t0), 32'd80);
    chk("after_glitch_pdata", 32'(bus.P_DATA), 32'h01);

    // Unsupported prescale behaves as 8
    send_frame(12, 1'b0, PAR_EVEN, 8'hC3, 1'b0, 1'b1, -1, t0);
    repeat (3) @(negedge CLK);
    chk("p12_latency", 32'(last_dv - t0), 32'd80);
    chk("p12_pdata", 32'(bus.P_DATA), 32'hC3);

    // Back-to-back frames at P=32, no idle between
    send_frame(32, 1'b0, PAR_EVEN, 8'h11, 1'b0, 1'b1, -1, t0);
    send_frame(32, 1'b0, PAR_EVEN, 8'h22, 1'b0, 1'b1, -1, t0b);
    repeat (3) @(negedge CLK);
    chk("b2b_first_latency", 32'(prev_dv - t0), 32'd320);
    chk("b2b_spacing", 32'(last_dv - prev_dv), 32'd320);
    chk("b2b_pdata", 32'(bus.P_DATA), 32'h22);

    // Reset at t0+40 of a frame, then 0xFF
    send_frame(8, 1'b0, PAR_EVEN, 8'h77, 1'b0, 1'b1, 40, t0);
    repeat (5) @(negedge CLK);
    send_frame(8, 1'b0, PAR_EVEN, 8'hFF, 1'b0, 1'b1, -1, t0);
    repeat (3) @(negedge CLK);
    chk("post_rst_latency", 32'(last_dv - t0), 32'd80);
    chk("post_rst_pdata", 32'(bus.P_DATA), 32'hFF);

    repeat (4) @(negedge CLK);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
